// File: rtl/hub75_scan.sv
// HUB75 row-scan driver with binary-coded modulation.
// For each row and bit-plane: shift WIDTH pixels (top and bottom half in parallel),
// pulse the latch, then enable the LEDs for BASE_ON << plane cycles. Planes step
// 0..BPC-1 within a row, rows step 0..2^RBITS-1 within a frame, continuously.
module hub75_scan #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned RBITS   = 4,
  parameter int unsigned BPC     = 4,
  parameter int unsigned PIX_CYC = 6,
  parameter int unsigned BASE_ON = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  output logic                             fb_rd_en,
  output logic [RBITS+$clog2(WIDTH)-1:0]   fb_rd_addr,
  input  logic [6*BPC-1:0]                 fb_rd_data,
  output logic                             r0,
  output logic                             g0,
  output logic                             b0,
  output logic                             r1,
  output logic                             g1,
  output logic                             b1,
  output logic                             sclk,
  output logic                             lat,
  output logic                             oe_n,
  output logic [RBITS-1:0]                 row_addr,
  output logic                             frame_done,
  output logic                             busy
);

  localparam int unsigned ColW   = $clog2(WIDTH);
  localparam int unsigned PixW   = $clog2(PIX_CYC);
  localparam int unsigned PlaneW = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int unsigned DispW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch,
    StDisplay
  } state_e;

  state_e              state_q, state_d;
  logic [RBITS-1:0]    row_q, row_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [PixW-1:0]     pix_q, pix_d;
  logic [PlaneW-1:0]   plane_q, plane_d;
  logic [DispW-1:0]    disp_q, disp_d;
  logic [5:0]          rgb_q, rgb_d;
  logic [RBITS-1:0]    row_addr_q, row_addr_d;
  logic                frame_done_q, frame_done_d;

  // Per-channel views of the framebuffer word, MSB-first channel order.
  logic [BPC-1:0] ch_r0, ch_g0, ch_b0, ch_r1, ch_g1, ch_b1;
  assign ch_r0 = fb_rd_data[5*BPC +: BPC];
  assign ch_g0 = fb_rd_data[4*BPC +: BPC];
  assign ch_b0 = fb_rd_data[3*BPC +: BPC];
  assign ch_r1 = fb_rd_data[2*BPC +: BPC];
  assign ch_g1 = fb_rd_data[1*BPC +: BPC];
  assign ch_b1 = fb_rd_data[0 +: BPC];

  // Terminal-count decodes shared by the FSM and the datapath.
  logic              pix_last, col_last, plane_last, row_last, disp_last, lat_second;
  logic [DispW-1:0]  on_len;

  assign pix_last   = (pix_q == PixW'(PIX_CYC - 1));
  assign col_last   = (col_q == ColW'(WIDTH - 1));
  assign plane_last = (plane_q == PlaneW'(BPC - 1));
  assign row_last   = (row_q == {RBITS{1'b1}});
  assign on_len     = DispW'(BASE_ON) << plane_q;
  assign disp_last  = (disp_q == (on_len - DispW'(1)));
  // The display counter doubles as the two-cycle latch counter.
  assign lat_second = disp_q[0];

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; enable is only consulted in idle and at the end of a frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StShift;
      end
      StShift: begin
        if (pix_last && col_last) state_d = StLatch;
      end
      StLatch: begin
        if (lat_second) state_d = StDisplay;
      end
      StDisplay: begin
        if (disp_last) begin
          state_d = (plane_last && row_last && !enable) ? StIdle : StShift;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: slot/column/plane/row counters, pixel capture, row select.
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    pix_d        = pix_q;
    plane_d      = plane_q;
    disp_d       = disp_q;
    rgb_d        = rgb_q;
    row_addr_d   = row_addr_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          row_d   = '0;
          col_d   = '0;
          pix_d   = '0;
          plane_d = '0;
          disp_d  = '0;
        end
      end
      StShift: begin
        pix_d = pix_q + PixW'(1);
        // Read data arrives in slot cycle 1; pins switch on cycle 2, while sclk is low.
        if (pix_q == PixW'(1)) begin
          rgb_d = {ch_r0[plane_q], ch_g0[plane_q], ch_b0[plane_q],
                   ch_r1[plane_q], ch_g1[plane_q], ch_b1[plane_q]};
        end
        if (pix_last) begin
          pix_d = '0;
          col_d = col_q + ColW'(1);
          if (col_last) disp_d = '0;
        end
      end
      StLatch: begin
        if (!lat_second) begin
          // Row select moves while lat is high, so it is settled for the whole display.
          row_addr_d = row_q;
          disp_d     = DispW'(1);
        end else begin
          disp_d = '0;
        end
      end
      StDisplay: begin
        disp_d = disp_q + DispW'(1);
        if (disp_last) begin
          disp_d = '0;
          if (plane_last) begin
            plane_d = '0;
            row_d   = row_q + RBITS'(1);
            if (row_last) frame_done_d = 1'b1;
          end else begin
            plane_d = plane_q + PlaneW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_q        <= '0;
      col_q        <= '0;
      pix_q        <= '0;
      plane_q      <= '0;
      disp_q       <= '0;
      rgb_q        <= '0;
      row_addr_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      pix_q        <= pix_d;
      plane_q      <= plane_d;
      disp_q       <= disp_d;
      rgb_q        <= rgb_d;
      row_addr_q   <= row_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    fb_rd_en   = (state_q == StShift) && (pix_q == '0);
    fb_rd_addr = {row_q, col_q};
    sclk       = (state_q == StShift) && (pix_q >= PixW'(PIX_CYC / 2));
    lat        = (state_q == StLatch);
    oe_n       = (state_q != StDisplay);
    busy       = (state_q != StIdle);
    {r0, g0, b0, r1, g1, b1} = rgb_q;
    row_addr   = row_addr_q;
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_hub75_scan.sv
// Bench for hub75_scan: random framebuffer and enable activity, checked every cycle
// against a model that derives the expected pin state from the position within a frame.
module tb_hub75_scan;

  localparam int WIDTH     = 64;
  localparam int RBITS     = 4;
  localparam int BPC       = 4;
  localparam int PIX_CYC   = 6;
  localparam int BASE_ON   = 8;
  localparam int AW        = RBITS + $clog2(WIDTH);
  localparam int DW        = 6 * BPC;
  localparam int SHIFT_LEN = WIDTH * PIX_CYC;
  localparam int PLANE_OVH = SHIFT_LEN + 2;
  localparam int ROW_LEN   = BPC * PLANE_OVH + BASE_ON * ((1 << BPC) - 1);
  localparam int FRAME_LEN = ROW_LEN * (1 << RBITS);

  logic             clock, reset, enable;
  logic             fb_rd_en;
  logic [AW-1:0]    fb_rd_addr;
  logic [DW-1:0]    fb_rd_data;
  logic             r0, g0, b0, r1, g1, b1;
  logic             sclk, lat, oe_n, busy, frame_done;
  logic [RBITS-1:0] row_addr;

  hub75_scan #(
    .WIDTH  (WIDTH),
    .RBITS  (RBITS),
    .BPC    (BPC),
    .PIX_CYC(PIX_CYC),
    .BASE_ON(BASE_ON)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .fb_rd_en  (fb_rd_en),
    .fb_rd_addr(fb_rd_addr),
    .fb_rd_data(fb_rd_data),
    .r0        (r0),
    .g0        (g0),
    .b0        (b0),
    .r1        (r1),
    .g1        (g1),
    .b1        (b1),
    .sclk      (sclk),
    .lat       (lat),
    .oe_n      (oe_n),
    .row_addr  (row_addr),
    .frame_done(frame_done),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Framebuffer: one-cycle read latency, garbage on cycles with no read pending.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];
    else          fb_rd_data <= DW'($urandom);
  end

  int n_vec, n_err;

  // Reference model state.
  bit               m_run;
  int               m_t;
  bit               m_fd;
  logic [5:0]       m_rgb;
  logic [RBITS-1:0] m_row_addr;
  int               m_frames;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Position within a frame -> row, plane and cycle offset within that plane.
  task automatic decode(input int t, output int row, output int plane, output int ph);
    int rem;
    row   = t / ROW_LEN;
    rem   = t % ROW_LEN;
    plane = 0;
    while (rem >= PLANE_OVH + (BASE_ON << plane)) begin
      rem   = rem - (PLANE_OVH + (BASE_ON << plane));
      plane = plane + 1;
    end
    ph = rem;
  endtask

  task automatic check_all();
    int  row, plane, ph;
    bit  sh;
    decode(m_t, row, plane, ph);
    sh = m_run && (ph < SHIFT_LEN);
    check_eq("busy", 32'(busy), 32'(m_run));
    check_eq("oe_n", 32'(oe_n), 32'(!(m_run && ph >= PLANE_OVH)));
    check_eq("lat", 32'(lat), 32'(m_run && ph >= SHIFT_LEN && ph < PLANE_OVH));
    check_eq("sclk", 32'(sclk), 32'(sh && (ph % PIX_CYC) >= PIX_CYC / 2));
    check_eq("fb_rd_en", 32'(fb_rd_en), 32'(sh && (ph % PIX_CYC) == 0));
    if (sh && (ph % PIX_CYC) == 0)
      check_eq("fb_rd_addr", 32'(fb_rd_addr), 32'(row * WIDTH + ph / PIX_CYC));
    check_eq("rgb", 32'({r0, g0, b0, r1, g1, b1}), 32'(m_rgb));
    check_eq("row_addr", 32'(row_addr), 32'(m_row_addr));
    check_eq("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  // Advance the model across one rising edge using the inputs the DUT sees there.
  task automatic advance();
    int row, plane, ph;
    logic [DW-1:0] d;
    if (reset) begin
      m_run = 0; m_t = 0; m_fd = 0; m_rgb = '0; m_row_addr = '0;
    end else if (!m_run) begin
      m_fd = 0;
      if (enable) begin
        m_run = 1;
        m_t   = 0;
      end
    end else begin
      m_fd = 0;
      decode(m_t, row, plane, ph);
      if (ph < SHIFT_LEN && (ph % PIX_CYC) == 1) begin
        d = mem[row * WIDTH + ph / PIX_CYC];
        m_rgb = {d[5*BPC+plane], d[4*BPC+plane], d[3*BPC+plane],
                 d[2*BPC+plane], d[1*BPC+plane], d[plane]};
      end
      if (ph == SHIFT_LEN) m_row_addr = RBITS'(row);
      if (m_t == FRAME_LEN - 1) begin
        m_fd  = 1;
        m_t   = 0;
        m_run = enable;
        m_frames++;
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    advance();
    @(negedge clock);
    check_all();
  endtask

  int dr, dp, dph, guard, hold;

  initial begin
    n_vec = 0; n_err = 0;
    m_run = 0; m_t = 0; m_fd = 0; m_rgb = '0; m_row_addr = '0; m_frames = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);

    // Reset held with enable high: everything at reset values.
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) begin
      cycle();
      check_eq("rst_addr", 32'(fb_rd_addr), 32'd0);
    end
    reset = 1'b0;

    // First frame with enable toggling randomly; it only matters near frame end.
    guard = 0;
    while (m_frames < 1 && guard < 2 * FRAME_LEN) begin
      enable = (!m_run || m_t > FRAME_LEN - 8) ? 1'b1 : 1'($urandom_range(0, 1));
      cycle();
      guard++;
    end
    if (m_frames < 1) begin
      n_err++;
      $display("FAIL frame1_timeout: got %0d frames expected 1", m_frames);
    end

    // Into the second frame, drop enable somewhere in row 7.
    enable = 1'b1;
    hold   = $urandom_range(0, ROW_LEN - 1);
    guard  = 0;
    dr     = 0;
    while (dr != 7 && guard < FRAME_LEN) begin
      cycle();
      decode(m_t, dr, dp, dph);
      guard++;
    end
    repeat (hold) cycle();
    enable = 1'b0;
    guard  = 0;
    while (m_run && guard < FRAME_LEN) begin
      cycle();
      guard++;
    end
    if (m_run) begin
      n_err++;
      $display("FAIL drain_timeout: got running expected idle");
    end
    repeat (50) cycle();

    // Restart, then reset in the middle of column 30 of row 2.
    enable = 1'b1;
    guard  = 0;
    dr = 0; dp = 0; dph = 0;
    while (!(m_run && dr == 2 && dp == 0 && dph == 30 * PIX_CYC + 3) && guard < FRAME_LEN) begin
      cycle();
      decode(m_t, dr, dp, dph);
      guard++;
    end
    if (guard >= FRAME_LEN) begin
      n_err++;
      $display("FAIL midshift_timeout: got no col-30 slot expected one");
    end
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (2000) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hub75_scan.md
Name: hub75_scan

Overview:
HUB75 row-scan driver clocked by the 60 MHz PLL output (12 MHz board clock → PLL → `clock`). It reads RGB pixel pairs (top half and bottom half) from the framebuffer read port, then shifts one bit-plane per row into the panel. It latches each plane and enables the LEDs for a binary-weighted time (BCM), stepping through all planes and rows continuously.

Parameters:
WIDTH, 64, panel columns; power of two.
RBITS, 4, row-address bits; panel has 2^RBITS scan rows (1/16 scan).
BPC, 4, bits per colour channel = number of BCM planes.
PIX_CYC, 6, clock cycles per shifted pixel; even, ≥6.
BASE_ON, 8, display cycles for plane 0; plane p lasts BASE_ON<<p; BASE_ON<<(BPC-1) < 2^16.

Ports:
clock  in  1  60 MHz PLL output clock
reset  in  1  synchronous, active-high
enable  in  1  run scanning; sampled as below
fb_rd_en  out  1  framebuffer read strobe
fb_rd_addr  out  RBITS+$clog2(WIDTH)  {row, col}
fb_rd_data  in  6*BPC  {R_top,G_top,B_top,R_bot,G_bot,B_bot}, MSB first; valid the cycle after fb_rd_en
r0,g0,b0,r1,g1,b1  out  1 each  panel colour pins (top: r0,g0,b0; bottom: r1,g1,b1)
sclk  out  1  panel shift clock
lat  out  1  panel latch
oe_n  out  1  panel output enable, active-low
row_addr  out  RBITS  panel row select (A..D)
frame_done  out  1  one-cycle pulse at end of each frame
busy  out  1  high in any state except IDLE

Behaviour:
- Single clock domain; reset is synchronous, active-high.
- Reset values: sclk=0, lat=0, oe_n=1, row_addr=0, colour pins=0, fb_rd_en=0, fb_rd_addr=0, frame_done=0, busy=0, state=IDLE, row=0, plane=0, col=0.
- Reset asserted in any state forces these values on the next edge; a partial shift is abandoned.
- States: IDLE, SHIFT, LATCH, DISPLAY. oe_n=0 only in DISPLAY.
- IDLE: when enable=1, go to SHIFT with row=0, plane=0, col=0.
- SHIFT: one slot of PIX_CYC cycles per column, col 0..WIDTH-1. Slot cycle k:
  - k=0: fb_rd_en=1, fb_rd_addr={row,col}; fb_rd_en=0 otherwise.
  - k=1: fb_rd_data is captured; colour pins take bit `plane` of each channel and are visible from k=2 until k=1 of the next slot.
  - sclk=1 for k in [PIX_CYC/2, PIX_CYC-1], else 0. This gives ≥1 cycle of setup and ≥2 cycles of hold around each rising edge.
  - After the last slot of col WIDTH-1, go to LATCH. SHIFT length is exactly WIDTH*PIX_CYC cycles.
- LATCH: 2 cycles, lat=1, sclk=0.
  - row_addr<=row on the first LATCH cycle; it is stable for the whole following DISPLAY.
  - Then go to DISPLAY.
- DISPLAY: oe_n=0 for exactly BASE_ON<<plane cycles, then:
  - plane<BPC-1: plane+1, same row, go to SHIFT.
  - else plane=0 and row+1 (wraps at 2^RBITS−1 → 0), go to SHIFT.
  - On the row wrap, frame_done=1 for the first cycle of the next state. That state is IDLE if enable=0 at the DISPLAY end, else SHIFT.
- enable is checked only in IDLE and at frame end. Deasserting enable mid-frame completes the frame first.
- Colour pins hold their last value in LATCH, DISPLAY and IDLE; they clear only on reset.
- The display counter is 16 bits. Column, plane and row counters wrap without overflow side effects.
- Brightness is linear in BCM weight. Gamma correction is done upstream in the framebuffer.

Test Plan:
- Reset: hold reset 3 cycles, enable=1 → all outputs at their reset values. First fb_rd_en comes 1 cycle after reset release with fb_rd_addr=0.
- Single pixel: framebuffer all zero except row 3, col 5, top R=4'b1010 → r0=1 only during col-5 slots of row 3, planes 1 and 3. Exactly 64 sclk rising edges per plane, none in LATCH or DISPLAY.
- Timing per plane (defaults): SHIFT=384 cycles, lat high 2 cycles, oe_n low 8/16/32/64 cycles for planes 0..3. row_addr changes only during lat=1.
- Frame wrap: run a full frame → 16 rows × 4 planes, then frame_done pulses once with row_addr=15 just displayed, and the next fb_rd_addr={0,0}. Frame length is 16×(4×386+120)=26624 cycles.
- enable drop mid-frame (row 7) → scanning finishes row 15, frame_done pulses, busy=0, oe_n=1 and no further fb_rd_en. Re-asserting enable restarts at row 0, plane 0.
- Reset mid-SHIFT (col 30, row 2) → next cycle IDLE with reset values. After release, restart at row 0, col 0 with no residual sclk edge or lat pulse.
